// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execution-stage ALU with single-cycle logic/arith ops and bit-serial shifts
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operation request (alu_op, alu_in_1, alu_in_2 valid)
//   in_ready   high in IDLE, when a request is accepted
//   alu_op     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA
//   alu_in_1   operand A
//   alu_in_2   operand B; low SHAMT_W bits give the shift amount for shifts
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer takes the result
//   alu_result registered result, held until the next accept
//   alu_zero   alu_result == 0
//   alu_lt     signed A < signed B, captured at accept
//   alu_ltu    unsigned A < unsigned B, captured at accept
module iterative_alu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_op,
    input  logic [XLEN-1:0]    alu_in_1,
    input  logic [XLEN-1:0]    alu_in_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_result,
    output logic               alu_zero,
    output logic               alu_lt,
    output logic               alu_ltu
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]    ONE_X = XLEN'(1);
    localparam logic [SHAMT_W-1:0] ONE_S = SHAMT_W'(1);

    state_t             state;
    logic [SHAMT_W-1:0] count;
    // Low two opcode bits of the shift in flight: 01 SLL, 10 SRL, 11 SRA.
    logic [1:0]         shift_kind;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [XLEN-1:0]    single_result;
    logic [XLEN-1:0]    shifted;

    assign shamt    = alu_in_2[SHAMT_W-1:0];
    assign is_shift = alu_op[2] & (alu_op[1] | alu_op[0]);

    // Result for everything that finishes at the accept edge. A shift by
    // zero is just a pass-through of operand A.
    always_comb begin
        single_result = '0;
        case (alu_op)
            3'b000:  single_result = alu_in_1 + alu_in_2;
            3'b001:  single_result = alu_in_1 + ~alu_in_2 + ONE_X;
            3'b010:  single_result = alu_in_1 & alu_in_2;
            3'b011:  single_result = alu_in_1 | alu_in_2;
            3'b100:  single_result = alu_in_1 ^ alu_in_2;
            default: single_result = alu_in_1;
        endcase
    end

    // One bit of shift per cycle; alu_result doubles as the work register.
    always_comb begin
        shifted = alu_result;
        case (shift_kind)
            2'b01:   shifted = {alu_result[XLEN-2:0], 1'b0};
            2'b10:   shifted = {1'b0, alu_result[XLEN-1:1]};
            2'b11:   shifted = {alu_result[XLEN-1], alu_result[XLEN-1:1]};
            default: shifted = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            shift_kind <= 2'b00;
            alu_result <= '0;
            alu_lt     <= 1'b0;
            alu_ltu    <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_lt     <= $signed(alu_in_1) < $signed(alu_in_2);
                        alu_ltu    <= alu_in_1 < alu_in_2;
                        in_ready   <= 1'b0;
                        shift_kind <= alu_op[1:0];
                        if (is_shift && shamt != '0) begin
                            alu_result <= alu_in_1;
                            count      <= shamt;
                            state      <= SHIFT;
                        end else begin
                            alu_result <= single_result;
                            state      <= DONE;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    alu_result <= shifted;
                    count      <= count - ONE_S;
                    if (count == ONE_S) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low in this cycle even if the result is
                    // taken, so a new request can only land a cycle later.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - self-checking bench for iterative_alu
module tb_iterative_alu;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] alu_in_1;
    logic [XLEN-1:0] alu_in_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_lt;
    logic            alu_ltu;

    int checks = 0;
    int errors = 0;

    iterative_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return $unsigned($signed(a) >>> sh);
        endcase
    endfunction

    // Edges after the accept edge before out_valid rises.
    function automatic int ref_wait(input logic [2:0] op, input logic [31:0] b);
        if (op >= 3'd5) return int'(b[4:0]);
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op with out_ready=1 and checks latency, result and flags.
    // Entered and left at #1 after a posedge with the DUT in IDLE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        int waited;
        logic [31:0] exp_r;
        exp_r = ref_result(op, a, b);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before issue: got %b want 1", name, in_ready);
        end
        alu_op = op; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_op = 3'($urandom); alu_in_1 = $urandom; alu_in_2 = $urandom;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        checks++;
        if (waited !== ref_wait(op, b)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, waited, ref_wait(op, b));
        end
        checks++;
        if (alu_result !== exp_r || alu_zero !== (exp_r == 0)) begin
            errors++;
            $display("FAIL %s result: got %h zero %b want %h zero %b", name, alu_result, alu_zero, exp_r, exp_r == 0);
        end
        checks++;
        if (alu_lt !== ($signed(a) < $signed(b)) || alu_ltu !== (a < b)) begin
            errors++;
            $display("FAIL %s flags: got lt %b ltu %b want lt %b ltu %b", name, alu_lt, alu_ltu,
                     $signed(a) < $signed(b), a < b);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== exp_r) begin
            errors++;
            $display("FAIL %s return to idle: got ov %b ir %b res %h want 0 1 %h", name, out_valid, in_ready, alu_result, exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_op = 3'd0; alu_in_1 = '0; alu_in_2 = '0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'h0 || alu_zero !== 1'b1 ||
            alu_lt !== 1'b0 || alu_ltu !== 1'b0) begin
            errors++;
            $display("FAIL reset state: got ov %b ir %b res %h z %b lt %b ltu %b want 0 1 0 1 0 0",
                     out_valid, in_ready, alu_result, alu_zero, alu_lt, alu_ltu);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        alu_op = 3'd5; alu_in_1 = 32'h0000_0001; alu_in_2 = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'h0 || alu_zero !== 1'b1) begin
            errors++;
            $display("FAIL mid-shift reset: got ov %b ir %b res %h z %b want 0 1 0 1", out_valid, in_ready, alu_result, alu_zero);
        end
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted shift out_valid pulses: got %0d want 0", seen);
        end
    endtask

    task automatic test_add_sub();
        run_op(3'd0, 32'h7FFF_FFFF, 32'h1, "add_wrap");
        checks++;
        if (alu_result !== 32'h8000_0000 || alu_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap const: got %h z %b want 80000000 z 0", alu_result, alu_zero);
        end
        run_op(3'd1, 32'd5, 32'd5, "sub_zero");
        checks++;
        if (alu_result !== 32'h0 || alu_zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero const: got %h z %b want 0 z 1", alu_result, alu_zero);
        end
    endtask

    task automatic test_shifts();
        run_op(3'd7, 32'h8000_0000, 32'd31, "sra31");
        run_op(3'd6, 32'h8000_0000, 32'd31, "srl31");
        run_op(3'd5, 32'h1, 32'd0, "sll0");
        run_op(3'd5, 32'h8000_0001, 32'hFFFF_FFE1, "sll1_upper_bits");
    endtask

    task automatic test_flags();
        run_op(3'd1, 32'hFFFF_FFFF, 32'h1, "flags_neg");
        run_op(3'd1, 32'h1, 32'hFFFF_FFFF, "flags_pos");
        run_op(3'd2, 32'h1234_5678, 32'h1234_5678, "flags_eq");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), $urandom, $urandom, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp_r, exp2;
        logic        exp_lt, exp_ltu;
        int          waited;
        int          bad;
        a = $urandom; b = $urandom;
        exp_r = a ^ b; exp_lt = $signed(a) < $signed(b); exp_ltu = a < b;
        alu_op = 3'd4; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        alu_op = 3'd0; alu_in_1 = 32'h0000_0010; alu_in_2 = 32'h0000_0020;
        exp2 = 32'h0000_0030;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        bad = 0;
        repeat (4) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== exp_r || alu_lt !== exp_lt || alu_ltu !== exp_ltu) begin
                errors++; bad++;
                $display("FAIL backpressure hold: got ov %b ir %b res %h lt %b ltu %b want 1 0 %h %b %b",
                         out_valid, in_ready, alu_result, alu_lt, alu_ltu, exp_r, exp_lt, exp_ltu);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== exp_r) begin
            errors++;
            $display("FAIL backpressure release: got ir %b ov %b res %h want 1 0 %h", in_ready, out_valid, alu_result, exp_r);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_result !== exp2) begin
            errors++;
            $display("FAIL backpressure next op: got ov %b res %h want 1 %h", out_valid, alu_result, exp2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        alu_op = 3'd2; alu_in_1 = 32'hF0F0_F0F0; alu_in_2 = 32'h0FF0_0FF0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'h00F0_00F0) begin
            errors++;
            $display("FAIL b2b and: got ov %b res %h want 1 00f000f0", out_valid, alu_result);
        end
        alu_op = 3'd3;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'h00F0_00F0) begin
            errors++;
            $display("FAIL b2b gap: got ov %b ir %b res %h want 0 1 00f000f0", out_valid, in_ready, alu_result);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'hFFF0_FFF0) begin
            errors++;
            $display("FAIL b2b or: got ov %b res %h want 1 fff0fff0", out_valid, alu_result);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_add_sub();
        test_shifts();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
